// File: rtl/m_countdown_timer.sv
// Loadable modulo down-counter: counts enabled ticks down from `law` and pulses `countdown`
// for one cycle on expiry. Supports one-shot, auto-reload, pause (stop) and resume.
module m_countdown_timer #(
  parameter int unsigned W = 6
) (
  input  logic         ck,
  input  logic         nres,
  input  logic         start,
  input  logic         stop,
  input  logic         resume,
  input  logic         en,
  input  logic         mode_reload,
  input  logic [W-1:0] law,
  output logic [W-1:0] q,
  output logic         busy,
  output logic         countdown
);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e state_q;

  always_ff @(posedge ck or negedge nres) begin
    if (!nres) begin
      state_q   <= StIdle;
      q         <= '0;
      busy      <= 1'b0;
      countdown <= 1'b0;
    end else begin
      countdown <= 1'b0;
      if (start) begin
        // A zero load expires immediately with a single pulse and never free-runs.
        if (law != '0) begin
          q       <= law;
          state_q <= StRun;
          busy    <= 1'b1;
        end else begin
          q         <= '0;
          state_q   <= StIdle;
          busy      <= 1'b0;
          countdown <= 1'b1;
        end
      end else begin
        unique case (state_q)
          StRun: begin
            if (stop) begin
              state_q <= StHold;
            end else if (en) begin
              if (q > W'(1)) begin
                q <= q - W'(1);
              end else begin
                countdown <= 1'b1;
                // mode_reload and law are sampled here, so both may change mid-count.
                if (mode_reload && (law != '0)) begin
                  q <= law;
                end else begin
                  q       <= '0;
                  state_q <= StIdle;
                  busy    <= 1'b0;
                end
              end
            end
          end
          StHold: begin
            if (resume) begin
              state_q <= StRun;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_m_countdown_timer.sv
// Directed bench for m_countdown_timer: a vector table for the main function plus
// hand-written sequences for the long period and the asynchronous reset abort.
module tb_m_countdown_timer;

  localparam int unsigned W = 6;

  logic         ck;
  logic         nres;
  logic         start;
  logic         stop;
  logic         resume;
  logic         en;
  logic         mode_reload;
  logic [W-1:0] law;
  logic [W-1:0] q;
  logic         busy;
  logic         countdown;

  int checks;
  int errors;

  m_countdown_timer #(.W(W)) dut (
    .ck          (ck),
    .nres        (nres),
    .start       (start),
    .stop        (stop),
    .resume      (resume),
    .en          (en),
    .mode_reload (mode_reload),
    .law         (law),
    .q           (q),
    .busy        (busy),
    .countdown   (countdown)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    logic         s;
    logic         sp;
    logic         r;
    logic         e;
    logic         m;
    logic [W-1:0] l;
    logic [W-1:0] eq;
    logic         eb;
    logic         ec;
  } vec_t;

  vec_t vt[$];

  task automatic v(input logic s, input logic sp, input logic r, input logic e, input logic m,
                   input int l, input int eq, input logic eb, input logic ec);
    vec_t x;
    x.s  = s;
    x.sp = sp;
    x.r  = r;
    x.e  = e;
    x.m  = m;
    x.l  = W'(l);
    x.eq = W'(eq);
    x.eb = eb;
    x.ec = ec;
    vt.push_back(x);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input int eq, input logic eb, input logic ec);
    chk({nm, " q"}, int'(q), eq);
    chk({nm, " busy"}, int'(busy), int'(eb));
    chk({nm, " countdown"}, int'(countdown), int'(ec));
  endtask

  task automatic step(input logic s, input logic sp, input logic r, input logic e, input logic m,
                      input int l, input int eq, input logic eb, input logic ec, input string nm);
    start       = s;
    stop        = sp;
    resume      = r;
    en          = e;
    mode_reload = m;
    law         = W'(l);
    @(posedge ck);
    #1;
    chk_out(nm, eq, eb, ec);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    nres        = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    resume      = 1'b0;
    en          = 1'b0;
    mode_reload = 1'b0;
    law         = '0;

    // Columns: start stop resume en mode_reload law | q busy countdown
    // Idle ignores en/stop/resume after release.
    v(0, 0, 0, 1, 0, 5, 0, 0, 0);
    v(0, 1, 1, 1, 0, 5, 0, 0, 0);
    // One-shot law=5.
    v(1, 0, 0, 1, 0, 5, 5, 1, 0);
    v(0, 0, 0, 1, 0, 5, 4, 1, 0);
    v(0, 0, 0, 1, 0, 5, 3, 1, 0);
    v(0, 0, 0, 1, 0, 5, 2, 1, 0);
    v(0, 0, 0, 1, 0, 5, 1, 1, 0);
    v(0, 0, 0, 1, 0, 5, 0, 0, 1);
    v(0, 0, 0, 1, 0, 5, 0, 0, 0);
    // Auto-reload law=3.
    v(1, 0, 0, 1, 1, 3, 3, 1, 0);
    v(0, 0, 0, 1, 1, 3, 2, 1, 0);
    v(0, 0, 0, 1, 1, 3, 1, 1, 0);
    v(0, 0, 0, 1, 1, 3, 3, 1, 1);
    v(0, 0, 0, 1, 1, 3, 2, 1, 0);
    v(0, 0, 0, 1, 1, 3, 1, 1, 0);
    v(0, 0, 0, 1, 1, 3, 3, 1, 1);
    // Zero load from RUN: one pulse, then silence even in reload mode.
    v(1, 0, 0, 0, 1, 0, 0, 0, 1);
    v(0, 0, 0, 1, 1, 0, 0, 0, 0);
    v(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // law=4 with en toggling.
    v(1, 0, 0, 0, 0, 4, 4, 1, 0);
    v(0, 0, 0, 1, 0, 4, 3, 1, 0);
    v(0, 0, 0, 0, 0, 4, 3, 1, 0);
    v(0, 0, 0, 1, 0, 4, 2, 1, 0);
    v(0, 0, 0, 0, 0, 4, 2, 1, 0);
    v(0, 0, 0, 1, 0, 4, 1, 1, 0);
    v(0, 0, 0, 0, 0, 4, 1, 1, 0);
    v(0, 0, 0, 1, 0, 4, 0, 0, 1);
    v(0, 0, 0, 0, 0, 4, 0, 0, 0);
    // law=6 pause/resume, then restart from HOLD.
    v(1, 0, 0, 1, 0, 6, 6, 1, 0);
    v(0, 0, 0, 1, 0, 6, 5, 1, 0);
    v(0, 0, 0, 1, 0, 6, 4, 1, 0);
    v(0, 1, 0, 1, 0, 6, 4, 1, 0);
    v(0, 0, 0, 1, 0, 6, 4, 1, 0);
    v(0, 0, 0, 1, 0, 6, 4, 1, 0);
    v(0, 1, 0, 1, 0, 6, 4, 1, 0);
    v(0, 0, 0, 1, 0, 6, 4, 1, 0);
    v(0, 0, 1, 1, 0, 6, 4, 1, 0);
    v(0, 0, 0, 1, 0, 6, 3, 1, 0);
    v(0, 1, 0, 1, 0, 6, 3, 1, 0);
    v(1, 0, 0, 1, 0, 6, 6, 1, 0);
    v(0, 0, 0, 1, 0, 6, 5, 1, 0);
    // start beats stop.
    v(1, 1, 0, 1, 0, 7, 7, 1, 0);
    v(0, 0, 0, 1, 0, 7, 6, 1, 0);
    // mode_reload sampled at expiry; reload with law=0 goes idle.
    v(1, 0, 0, 1, 0, 2, 2, 1, 0);
    v(0, 0, 0, 1, 1, 2, 1, 1, 0);
    v(0, 0, 0, 1, 1, 2, 2, 1, 1);
    v(0, 0, 0, 1, 1, 2, 1, 1, 0);
    v(0, 0, 0, 1, 1, 0, 0, 0, 1);
    v(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // Reload picks up the current law.
    v(1, 0, 0, 1, 1, 2, 2, 1, 0);
    v(0, 0, 0, 1, 1, 2, 1, 1, 0);
    v(0, 0, 0, 1, 1, 5, 5, 1, 1);
    v(0, 0, 0, 1, 0, 5, 4, 1, 0);

    #12;
    chk_out("reset", 0, 1'b0, 1'b0);
    nres = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].s, vt[i].sp, vt[i].r, vt[i].e, vt[i].m, int'(vt[i].l),
           int'(vt[i].eq), vt[i].eb, vt[i].ec, $sformatf("vec%0d", i));
    end

    // Maximum load: pulse after exactly 63 enabled ticks.
    step(1, 0, 0, 1, 0, 63, 63, 1, 0, "max load");
    for (int i = 62; i >= 1; i--) begin
      step(0, 0, 0, 1, 0, 63, i, 1, 0, $sformatf("max tick q=%0d", i));
    end
    step(0, 0, 0, 1, 0, 63, 0, 0, 1, "max expiry");
    step(0, 0, 0, 1, 0, 63, 0, 0, 0, "max after");

    // Asynchronous reset mid-count aborts without a pulse.
    step(1, 0, 0, 1, 0, 5, 5, 1, 0, "abort load");
    step(0, 0, 0, 1, 0, 5, 4, 1, 0, "abort t1");
    step(0, 0, 0, 1, 0, 5, 3, 1, 0, "abort t2");
    step(0, 0, 0, 1, 0, 5, 2, 1, 0, "abort t3");
    #2;
    nres = 1'b0;
    #1;
    chk_out("async reset", 0, 1'b0, 1'b0);
    @(posedge ck);
    #1;
    chk_out("held reset", 0, 1'b0, 1'b0);
    #2;
    nres = 1'b1;
    step(0, 0, 0, 1, 0, 5, 0, 0, 0, "release no start");
    step(1, 0, 0, 1, 0, 3, 3, 1, 0, "post reset load");
    step(0, 0, 0, 1, 0, 3, 2, 1, 0, "post reset tick");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_countdown_timer.md
Name: m_countdown_timer

Overview:
- Loadable modulo down-counter and timer.
- It is the count-down counterpart of the team's modulo up-counter. It loads a terminal value `law`, decrements on enabled clocks, and emits a one-cycle `countdown` pulse when the count expires.
- It supports one-shot and auto-reload operation, plus pause and resume.
- It is used as a programmable delay or period generator alongside the up-counter in the lab designs.

Parameters:
W, 6, width of `law` and `q` in bits.

Ports:
ck  input  1  clock; all state changes on rising edge
nres  input  1  asynchronous, active-low reset
start  input  1  level sampled each edge; loads `law` and begins counting
stop  input  1  pauses a running count (RUN -> HOLD)
resume  input  1  continues a paused count (HOLD -> RUN)
en  input  1  count-enable tick; decrement happens only on edges where `en`=1
mode_reload  input  1  1 = auto-reload on expiry; 0 = one-shot
law  input  W  load value / period in enabled ticks; sampled on start and on every reload
q  output  W  current count (registered)
busy  output  1  1 while state is RUN or HOLD (registered)
countdown  output  1  one-cycle expiry pulse (registered)

Behaviour:
- Reset:
  - `nres`=0 asynchronously forces state=IDLE, `q`=0, `busy`=0, `countdown`=0.
  - Reset asserted mid-count aborts the count with no pulse.
  - Release is synchronous to the next `ck` edge; no count happens on the release edge unless `start`=1.
- States: IDLE, RUN, HOLD. `busy` is 1 in RUN and HOLD.
- Input priority on each edge: `start` > `stop` > `resume` > `en`.
- `countdown` defaults to 0 each cycle. It is 1 only in the cycle following an expiry edge or a zero-load edge.
- start=1, in any state:
  - If `law`!=0: `q`<=`law`, state<=RUN, `countdown`<=0. `en` is ignored on this edge.
  - If `law`==0: `q`<=0, state<=IDLE, `countdown`<=1. Exactly one pulse, in both modes; never free-runs.
- RUN with `stop`=1: state<=HOLD; `q` is held and `en` is ignored.
- HOLD:
  - `resume`=1: state<=RUN. No decrement on this edge.
  - Otherwise: hold `q`.
  - `stop` while already in HOLD: no effect.
- RUN with `en`=1 and `q`>1: `q`<=`q`-1.
- RUN with `en`=1 and `q`==1 (expiry edge): `countdown`<=1, then:
  - `mode_reload`=1 and `law`!=0: `q`<=`law` (current value), stay in RUN.
  - `mode_reload`=1 and `law`==0: `q`<=0, state<=IDLE.
  - `mode_reload`=0: `q`<=0, state<=IDLE.
- RUN with `en`=0: hold `q`.
- Period: exactly `law` enabled ticks between load and pulse, and between successive pulses in reload mode.
- IDLE: `q` holds its last value (0 after expiry or reset). `en`, `stop`, `resume` are ignored.
- `mode_reload` is sampled only on the expiry edge, so it may change mid-count.
- Arithmetic is unsigned W-bit. `q` never wraps below 0.
- Maximum `law` is 2^W-1 (63 at default W).

Test Plan:
- nres=0 -> q=0, busy=0, countdown=0. Release, then start with law=5, mode_reload=0, en=1 constant -> q = 5,4,3,2,1,0 on successive edges; countdown=1 for exactly the one cycle after q leaves 1; busy falls with it.
- law=3, mode_reload=1, en=1 -> q cycles 3,2,1,3,2,1...; countdown pulses every 3 cycles; busy stays 1.
- law=4, en toggling 1,0,1,0 -> each decrement takes 2 cycles; pulse arrives after 4 enabled ticks (8 cycles).
- law=6: stop at q=4 for 5 cycles with en=1 -> q holds 4, busy=1. Resume -> next decrement on the following enabled edge, to q=3. Start asserted in HOLD -> reload to q=6.
- start with law=0 -> single countdown pulse, state IDLE, q=0; no pulse in any later cycle. Start with law=63 -> pulse after 63 enabled ticks.
- nres asserted while in RUN at q=2 -> immediately q=0, busy=0, countdown=0, no pulse. Simultaneous start+stop -> start wins (q=law, RUN).
